// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: boot vector, two-word assembly, interrupt injection, stall/redirect
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   stall                    hold all state and outputs this cycle
//   redirect, redirect_pc    taken branch/jump/return; load pc from redirect_pc
//   irq                      level interrupt request; rising edge is latched as pending
//   imem_data / imem_addr    combinational instruction-memory read port
//   out_valid                out_* hold a complete instruction for IF/ID
//   out_instr, out_imm       instruction word and immediate (0 for one-word instructions)
//   out_pc                   address of the instruction's first word (return address for interrupts)
//   out_is_int               out_* is the injected interrupt pseudo-op

module fetch_unit #(
    parameter int W       = 16,
    parameter int AW      = 32,
    parameter int IMM_BIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          irq,
    input  logic [W-1:0]  imem_data,
    output logic [AW-1:0] imem_addr,
    output logic          out_valid,
    output logic [W-1:0]  out_instr,
    output logic [W-1:0]  out_imm,
    output logic [AW-1:0] out_pc,
    output logic          out_is_int
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_IMM,
        S_VEC
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          irq_pend_q, irq_pend_d;
    logic          prev_irq_q, prev_irq_d;
    logic [W-1:0]  hold_q, hold_d;
    logic [AW-1:0] hold_pc_q, hold_pc_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_instr_q, out_instr_d;
    logic [W-1:0]  out_imm_q, out_imm_d;
    logic [AW-1:0] out_pc_q, out_pc_d;
    logic          out_is_int_q, out_is_int_d;

    logic          irq_edge;

    // Word 0 holds the boot vector, word 1 the interrupt vector.
    always_comb begin
        case (state_q)
            S_BOOT:  imem_addr = '0;
            S_VEC:   imem_addr = AW'(1);
            default: imem_addr = pc_q;
        endcase
    end

    assign irq_edge = irq & ~prev_irq_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        hold_pc_d    = hold_pc_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_imm_d    = out_imm_q;
        out_pc_d     = out_pc_q;
        out_is_int_d = out_is_int_q;
        // The edge detector runs every cycle, including stall and redirect cycles.
        prev_irq_d   = irq;
        irq_pend_d   = irq_pend_q | irq_edge;

        // Redirect has no meaning before the boot vector is loaded.
        if (redirect && state_q != S_BOOT) begin
            pc_d         = redirect_pc;
            state_d      = S_FETCH;
            out_valid_d  = 1'b0;
            out_is_int_d = 1'b0;
        end else if (!stall) begin
            case (state_q)
                S_BOOT: begin
                    pc_d        = AW'(imem_data);
                    state_d     = S_FETCH;
                    out_valid_d = 1'b0;
                end
                S_FETCH: begin
                    if (irq_pend_q) begin
                        // pc is left pointing at the interrupted instruction so it is the return address.
                        out_valid_d  = 1'b1;
                        out_is_int_d = 1'b1;
                        out_instr_d  = '0;
                        out_imm_d    = '0;
                        out_pc_d     = pc_q;
                        irq_pend_d   = irq_edge;
                        state_d      = S_VEC;
                    end else if (imem_data[IMM_BIT]) begin
                        hold_d      = imem_data;
                        hold_pc_d   = pc_q;
                        pc_d        = pc_q + AW'(1);
                        out_valid_d = 1'b0;
                        state_d     = S_IMM;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_is_int_d = 1'b0;
                        out_instr_d  = imem_data;
                        out_imm_d    = '0;
                        out_pc_d     = pc_q;
                        pc_d         = pc_q + AW'(1);
                    end
                end
                S_IMM: begin
                    out_valid_d  = 1'b1;
                    out_is_int_d = 1'b0;
                    out_instr_d  = hold_q;
                    out_imm_d    = imem_data;
                    out_pc_d     = hold_pc_q;
                    pc_d         = pc_q + AW'(1);
                    state_d      = S_FETCH;
                end
                default: begin
                    pc_d        = AW'(imem_data);
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_q         <= '0;
            irq_pend_q   <= 1'b0;
            prev_irq_q   <= 1'b0;
            hold_q       <= '0;
            hold_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_imm_q    <= '0;
            out_pc_q     <= '0;
            out_is_int_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            irq_pend_q   <= irq_pend_d;
            prev_irq_q   <= prev_irq_d;
            hold_q       <= hold_d;
            hold_pc_q    <= hold_pc_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_imm_q    <= out_imm_d;
            out_pc_q     <= out_pc_d;
            out_is_int_q <= out_is_int_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_imm    = out_imm_q;
    assign out_pc     = out_pc_q;
    assign out_is_int = out_is_int_q;

endmodule
